// File: rtl/arcade_pkg.sv
// Shared types for the arcade game switcher: FSM state encoding and button bus width.
package arcade_pkg;

  localparam int BTN_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BLANK  = 2'd1,
    LAUNCH = 2'd2
  } sw_state_e;

endpackage

// File: rtl/game_slice_mux.sv
// Picks slice [idx] of width W out of a packed bus holding N equal slices.
module game_slice_mux #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
) (
  input  logic [N*W-1:0]   bus,
  input  logic [SEL_W-1:0] idx,
  output logic [W-1:0]     data
);

  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == SEL_W'(i)) data = bus[i*W +: W];
    end
  end

endmodule

// File: rtl/game_switcher.sv
// Switches between NUM_GAMES game cores with a blanking gap and a launch reset pulse.
// Optional per-game high-score tracking is enabled with GAME_SWITCHER_HISCORE_EN.
module game_switcher
  import arcade_pkg::*;
#(
  parameter int NUM_GAMES    = 4,
  parameter int SEL_W        = 2,
  parameter int LED_W        = 16,
  parameter int GRID_W       = 64,
  parameter int SCORE_W      = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SEL_W-1:0]             game_select,
  input  logic [BTN_W-1:0]             btn_pulse,
  input  logic [NUM_GAMES*LED_W-1:0]   game_led,
  input  logic [NUM_GAMES*GRID_W-1:0]  game_grid,
  input  logic [NUM_GAMES-1:0]         game_check_ok,
  input  logic [NUM_GAMES*SCORE_W-1:0] game_score,
  output logic [NUM_GAMES*BTN_W-1:0]   btn_to_game,
  output logic [NUM_GAMES-1:0]         game_rst,
  output logic [LED_W-1:0]             led_out,
  output logic [GRID_W-1:0]            grid_out,
  output logic                         check_ok_out,
  output logic [SCORE_W-1:0]           score_out,
  output logic [SEL_W-1:0]             active_game,
  output logic                         switching
`ifdef GAME_SWITCHER_HISCORE_EN
  ,
  output logic [SCORE_W-1:0]           hiscore_out
`endif
);

  localparam int LOW_W = LED_W - SEL_W;
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

  sw_state_e          state_reg;
  logic [SEL_W-1:0]   target_reg;
  logic [SEL_W-1:0]   active_reg;
  logic [CNT_W-1:0]   blank_cnt_reg;
  logic [LOW_W-1:0]   led_reg;
  logic [GRID_W-1:0]  grid_reg;
  logic               check_reg;
  logic [SCORE_W-1:0] score_reg;

  logic [NUM_GAMES*LOW_W-1:0] led_low_bus;
  logic [LOW_W-1:0]           led_sel;
  logic [GRID_W-1:0]          grid_sel;
  logic [SCORE_W-1:0]         score_sel;
  logic                       check_sel;
  logic                       sel_valid;
  logic                       run_now;

  assign sel_valid = int'(game_select) < NUM_GAMES;
  assign run_now   = !rst && (state_reg == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LAUNCH;
      target_reg    <= '0;
      active_reg    <= '0;
      blank_cnt_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (sel_valid && game_select != active_reg) begin
            state_reg     <= BLANK;
            target_reg    <= game_select;
            blank_cnt_reg <= CNT_LOAD;
          end
        end
        BLANK: begin
          // Any valid change of mind restarts the full blanking period.
          if (sel_valid && game_select != target_reg) begin
            target_reg    <= game_select;
            blank_cnt_reg <= CNT_LOAD;
          end else if (blank_cnt_reg == '0) begin
            state_reg <= LAUNCH;
          end else begin
            blank_cnt_reg <= blank_cnt_reg - CNT_W'(1);
          end
        end
        LAUNCH: begin
          active_reg <= target_reg;
          state_reg  <= RUN;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  // The top SEL_W bits of each game's LED bus are replaced by the active index.
  for (genvar gi = 0; gi < NUM_GAMES; gi++) begin : g_route
    assign led_low_bus[gi*LOW_W +: LOW_W] = game_led[gi*LED_W +: LOW_W];
    assign btn_to_game[gi*BTN_W +: BTN_W] =
        (run_now && active_reg == SEL_W'(gi)) ? btn_pulse : '0;
    assign game_rst[gi] = rst || (state_reg == LAUNCH && target_reg == SEL_W'(gi));
  end

  game_slice_mux #(.N(NUM_GAMES), .W(LOW_W), .SEL_W(SEL_W)) u_led_mux (
    .bus(led_low_bus), .idx(active_reg), .data(led_sel)
  );
  game_slice_mux #(.N(NUM_GAMES), .W(GRID_W), .SEL_W(SEL_W)) u_grid_mux (
    .bus(game_grid), .idx(active_reg), .data(grid_sel)
  );
  game_slice_mux #(.N(NUM_GAMES), .W(SCORE_W), .SEL_W(SEL_W)) u_score_mux (
    .bus(game_score), .idx(active_reg), .data(score_sel)
  );
  game_slice_mux #(.N(NUM_GAMES), .W(1), .SEL_W(SEL_W)) u_check_mux (
    .bus(game_check_ok), .idx(active_reg), .data(check_sel)
  );

  always_ff @(posedge clk) begin
    if (rst || state_reg != RUN) begin
      led_reg   <= '0;
      grid_reg  <= '0;
      check_reg <= 1'b0;
      score_reg <= '0;
    end else begin
      led_reg   <= led_sel;
      grid_reg  <= grid_sel;
      check_reg <= check_sel;
      score_reg <= score_sel;
    end
  end

  assign active_game  = rst ? '0 : active_reg;
  assign switching    = !rst && (state_reg != RUN);
  assign led_out      = {active_game, led_reg};
  assign grid_out     = grid_reg;
  assign check_ok_out = check_reg;
  assign score_out    = score_reg;

`ifdef GAME_SWITCHER_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_reg [NUM_GAMES];
  logic [SCORE_W-1:0] hiscore_out_reg;

  // Only rst clears the table; a game's own launch reset keeps its record.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GAMES; i++) hiscore_reg[i] <= '0;
      hiscore_out_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_GAMES; i++) begin
        if (state_reg == RUN && active_reg == SEL_W'(i) && score_sel > hiscore_reg[i])
          hiscore_reg[i] <= score_sel;
      end
      hiscore_out_reg <= hiscore_reg[active_reg];
    end
  end

  assign hiscore_out = hiscore_out_reg;
`endif

endmodule

// File: tb/tb_game_switcher.sv
// Scoreboard bench for game_switcher (4-game instance plus a 3-game instance for range checks).
module tb_game_switcher;

  localparam int N = 4, SW = 2, LW = 16, GW = 64, SCW = 8, B = 4;
  localparam int S_RUN = 0, S_BLANK = 1, S_LAUNCH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [SW-1:0]    game_select = '0;
  logic [4:0]       btn_pulse = '0;
  logic [N*LW-1:0]  game_led = '0;
  logic [N*GW-1:0]  game_grid = '0;
  logic [N-1:0]     game_check_ok = '0;
  logic [N*SCW-1:0] game_score = '0;
  logic [N*5-1:0]   btn_to_game;
  logic [N-1:0]     game_rst;
  logic [LW-1:0]    led_out;
  logic [GW-1:0]    grid_out;
  logic             check_ok_out;
  logic [SCW-1:0]   score_out;
  logic [SW-1:0]    active_game;
  logic             switching;
  logic [SCW-1:0]   hiscore_out;

  logic [SW-1:0]    sel3 = '0;
  logic [14:0]      btn3;
  logic [2:0]       game_rst3;
  logic [LW-1:0]    led3;
  logic [GW-1:0]    grid3;
  logic             chk3;
  logic [SCW-1:0]   score3, hi3;
  logic [SW-1:0]    active3;
  logic             switching3;

  always #5 clk = ~clk;

  game_switcher #(.NUM_GAMES(N), .SEL_W(SW), .LED_W(LW), .GRID_W(GW), .SCORE_W(SCW), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .game_select(game_select), .btn_pulse(btn_pulse),
    .game_led(game_led), .game_grid(game_grid), .game_check_ok(game_check_ok), .game_score(game_score),
    .btn_to_game(btn_to_game), .game_rst(game_rst), .led_out(led_out), .grid_out(grid_out),
    .check_ok_out(check_ok_out), .score_out(score_out), .active_game(active_game), .switching(switching)
`ifdef GAME_SWITCHER_HISCORE_EN
    , .hiscore_out(hiscore_out)
`endif
  );

  game_switcher #(.NUM_GAMES(3), .SEL_W(SW), .LED_W(LW), .GRID_W(GW), .SCORE_W(SCW), .BLANK_CYCLES(B)) dut3 (
    .clk(clk), .rst(rst), .game_select(sel3), .btn_pulse(btn_pulse),
    .game_led({3{16'h1234}}), .game_grid({3{64'h0f0f_0f0f_0f0f_0f0f}}), .game_check_ok(3'b101),
    .game_score({3{8'h11}}), .btn_to_game(btn3), .game_rst(game_rst3), .led_out(led3), .grid_out(grid3),
    .check_ok_out(chk3), .score_out(score3), .active_game(active3), .switching(switching3)
`ifdef GAME_SWITCHER_HISCORE_EN
    , .hiscore_out(hi3)
`endif
  );

  typedef struct packed {
    logic [LW-1:0]  led;
    logic [GW-1:0]  grid;
    logic           chk;
    logic [SCW-1:0] score;
    logic [SCW-1:0] hi;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int m_st = S_LAUNCH, m_tgt = 0, m_act = 0, m_left = 0;
  logic [SCW-1:0] hi_m [N];
  logic [SCW-1:0] score_cfg [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check settled outputs, queue next registered outputs.
  task automatic step(input logic r, input logic [SW-1:0] sel, input logic [4:0] btn);
    exp_t e;
    logic [N*5-1:0] eb;
    logic [N-1:0] er;
    logic [SW-1:0] ea;
    logic esw;
    @(negedge clk);
    rst = r;
    game_select = sel;
    btn_pulse = btn;
    for (int i = 0; i < N; i++) begin
      game_led[i*LW +: LW] = LW'($urandom);
      game_grid[i*GW +: GW] = {$urandom, $urandom};
      game_check_ok[i] = 1'($urandom);
      game_score[i*SCW +: SCW] = score_cfg[i];
    end
    #1;
    ea = r ? '0 : SW'(m_act);
    esw = !r && m_st != S_RUN;
    eb = '0;
    if (!r && m_st == S_RUN) eb[m_act*5 +: 5] = btn;
    er = r ? '1 : ((m_st == S_LAUNCH) ? (N'(1) << m_tgt) : '0);
    check_eq("active_game", 64'(active_game), 64'(ea));
    check_eq("switching", 64'(switching), 64'(esw));
    check_eq("btn_to_game", 64'(btn_to_game), 64'(eb));
    check_eq("game_rst", 64'(game_rst), 64'(er));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("led_out", 64'(led_out), 64'({ea, e.led[LW-SW-1:0]}));
      check_eq("grid_out", grid_out, e.grid);
      check_eq("check_ok_out", 64'(check_ok_out), 64'(e.chk));
      check_eq("score_out", 64'(score_out), 64'(e.score));
`ifdef GAME_SWITCHER_HISCORE_EN
      check_eq("hiscore_out", 64'(hiscore_out), 64'(e.hi));
`endif
    end
    e = '0;
    if (!r && m_st == S_RUN) begin
      e.led = game_led[m_act*LW +: LW];
      e.grid = game_grid[m_act*GW +: GW];
      e.chk = game_check_ok[m_act];
      e.score = score_cfg[m_act];
    end
    e.hi = r ? '0 : hi_m[m_act];
    exp_q.push_back(e);
    if (r) begin
      m_st = S_LAUNCH; m_tgt = 0; m_act = 0;
      for (int i = 0; i < N; i++) hi_m[i] = '0;
    end else begin
      if (m_st == S_RUN && score_cfg[m_act] > hi_m[m_act]) hi_m[m_act] = score_cfg[m_act];
      case (m_st)
        S_RUN: if (int'(sel) != m_act) begin m_st = S_BLANK; m_tgt = int'(sel); m_left = B; end
        S_BLANK: begin
          if (int'(sel) != m_tgt) begin
            m_tgt = int'(sel); m_left = B;
          end else begin
            m_left--;
            if (m_left == 0) m_st = S_LAUNCH;
          end
        end
        default: begin m_act = m_tgt; m_st = S_RUN; end
      endcase
    end
  endtask

  initial begin
    int sw_cnt, rst_at;
    logic [N-1:0] rst_seen;
    logic [GW-1:0] saved;
    logic [SW-1:0] rsel;
    for (int i = 0; i < N; i++) begin score_cfg[i] = 8'($urandom_range(0, 9)); hi_m[i] = '0; end

    step(1, 0, 0); step(1, 0, 5'b11111);
    step(0, 0, 0);
    check_eq("rst_release_pulse", 64'(game_rst), 64'(4'b0001));
    for (int k = 0; k < 3; k++) step(0, 0, 5'b00001);
    check_eq("led_indicator_g0", 64'(led_out[15:14]), 64'(0));

    sw_cnt = 0; rst_at = 0; saved = '0;
    for (int k = 1; k <= 8; k++) begin
      step(0, 2, 5'b00100);
      if (switching) sw_cnt++;
      if (game_rst == 4'b0100) rst_at = k;
      if (k == 7) saved = game_grid[2*GW +: GW];
    end
    check_eq("switch_cycles", 64'(sw_cnt), 64'(5));
    check_eq("launch_cycle", 64'(rst_at), 64'(6));
    check_eq("grid_game2", grid_out, saved);

    for (int k = 0; k < 8; k++) step(0, 3, 5'b01000);
    step(0, 3, 5'b00100);
    check_eq("btn_route_g3", 64'(btn_to_game[19:15]), 64'(5'b00100));

    for (int k = 0; k < 8; k++) step(0, 0, 0);
    rst_seen = '0;
    step(0, 1, 0); rst_seen |= game_rst;
    step(0, 1, 0); rst_seen |= game_rst;
    step(0, 3, 0); rst_seen |= game_rst;
    for (int k = 0; k < 8; k++) begin step(0, 3, 5'b10000); rst_seen |= game_rst; end
    check_eq("retarget_resets", 64'(rst_seen), 64'(4'b1000));

    step(0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 3, 0);
    check_eq("return_active", 64'(active_game), 64'(3));

    step(0, 1, 0); step(0, 1, 0); step(1, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0);
    check_eq("rst_mid_blank", 64'(active_game), 64'(0));

    rsel = '0;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) rsel = SW'($urandom);
      score_cfg[$urandom_range(0, N-1)] = 8'($urandom_range(0, 9));
      step(0, rsel, 5'($urandom));
    end

    score_cfg[1] = 8'd0;
    for (int k = 0; k < 8; k++) step(0, 1, 0);
    score_cfg[1] = 8'd10; step(0, 1, 0);
    score_cfg[1] = 8'd40; step(0, 1, 0);
    score_cfg[1] = 8'd20; step(0, 1, 0);
    step(0, 1, 0); step(0, 1, 0);
`ifdef GAME_SWITCHER_HISCORE_EN
    check_eq("hiscore_g1", 64'(hiscore_out), 64'(40));
`endif
    for (int k = 0; k < 8; k++) step(0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 0);
`ifdef GAME_SWITCHER_HISCORE_EN
    check_eq("hiscore_g1_kept", 64'(hiscore_out), 64'(40));
`endif

    sel3 = 2'd3;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0);
      check_eq("oor_switching", 64'(switching3), 64'(0));
      check_eq("oor_game_rst", 64'(game_rst3), 64'(0));
      check_eq("oor_active", 64'(active3), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
